np_matrix_mult_accum: RTL and testbench



---
 rtl/ffn_pkg.sv | 37 +++
 rtl/np_matrix_mult_accum_if.sv | 33 +++
 rtl/np_sum_fifo.sv | 72 +++++++
 rtl/np_matrix_mult_accum.sv | 183 ++++++++++++++++++
 tb/tb_np_matrix_mult_accum.sv | 348 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ffn_pkg.sv
// ----------------------------------------------------------------------------
// ffn_pkg
// Shared definitions for the FFN matrix-multiply datapath:
//   - accum_state_t : state encoding of the dot-product accumulator FSM
//   - PROD_WIDTH / ACC_WIDTH / OUT_WIDTH : default datapath widths
//   - sat_to_out    : clamps a wide signed value into an out_width-bit range
// ----------------------------------------------------------------------------
package ffn_pkg;

    localparam int PROD_WIDTH = 32;
    localparam int ACC_WIDTH  = 48;
    localparam int OUT_WIDTH  = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2
    } accum_state_t;

    // Works on a 64-bit signed carrier so any accumulator up to 63 bits can be
    // sign-extended into it; the caller truncates the result to out_width bits.
    function automatic logic [63:0] sat_to_out(input logic signed [63:0] value,
                                               input int                 out_width);
        logic signed [63:0] max_v;
        logic signed [63:0] min_v;
        max_v = (64'sd1 <<< (out_width - 32'sd1)) - 64'sd1;
        min_v = -max_v - 64'sd1;
        if (value > max_v) begin
            return max_v;
        end else if (value < min_v) begin
            return min_v;
        end else begin
            return value;
        end
    endfunction

endpackage

// File: rtl/np_matrix_mult_accum_if.sv
// ----------------------------------------------------------------------------
// np_matrix_mult_accum_if
// Groups the product stream (into the accumulator) and the finished-sum
// valid/ready stream (out of the accumulator).
//   master : environment side - drives products and sum_ready
//   slave  : accumulator side - consumes products, presents sums
// ----------------------------------------------------------------------------
interface np_matrix_mult_accum_if #(
    parameter int PROD_WIDTH = 32,
    parameter int OUT_WIDTH  = 32,
    parameter int IDX_WIDTH  = 3
) ();

    logic                  prod_valid;
    logic [PROD_WIDTH-1:0] prod_data;
    logic                  prod_last;

    logic [OUT_WIDTH-1:0]  sum_data;
    logic [IDX_WIDTH-1:0]  sum_index;
    logic                  sum_valid;
    logic                  sum_ready;

    modport master (
        output prod_valid, prod_data, prod_last, sum_ready,
        input  sum_data, sum_index, sum_valid
    );

    modport slave (
        input  prod_valid, prod_data, prod_last, sum_ready,
        output sum_data, sum_index, sum_valid
    );

endinterface

// File: rtl/np_sum_fifo.sv
// ----------------------------------------------------------------------------
// np_sum_fifo
// Synchronous FIFO holding finished sums. The head is read straight from the
// storage registers, so an entry pushed on one edge is visible at the head
// from the next cycle on and stays stable until popped.
// Ports:
//   clock, reset (async active-low)
//   flush      : empties the FIFO (pointers to zero)
//   push/push_data : write request; ignored when full unless a pop coincides
//   pop        : remove head; ignored when empty
//   pop_data   : current head entry
//   full/empty : occupancy flags
// DEPTH must be a power of two and at least 2.
// ----------------------------------------------------------------------------
module np_sum_fifo #(
    parameter int WIDTH = 35,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int ADDR_WIDTH = $clog2(DEPTH);
    localparam int PTR_WIDTH  = ADDR_WIDTH + 1;
    localparam logic [PTR_WIDTH-1:0] PTR_ONE = PTR_WIDTH'(1);

    logic [WIDTH-1:0]     mem_r [DEPTH];
    logic [PTR_WIDTH-1:0] wr_ptr_r;
    logic [PTR_WIDTH-1:0] rd_ptr_r;
    logic                 wr_en_s;
    logic                 rd_en_s;

    // Extra pointer MSB distinguishes full from empty when addresses match.
    assign empty = (wr_ptr_r == rd_ptr_r);
    assign full  = (wr_ptr_r[ADDR_WIDTH] != rd_ptr_r[ADDR_WIDTH]) &&
                   (wr_ptr_r[ADDR_WIDTH-1:0] == rd_ptr_r[ADDR_WIDTH-1:0]);

    // A pop in the same cycle frees the slot the push is about to reuse.
    assign wr_en_s  = push && (!full || pop);
    assign rd_en_s  = pop && !empty;
    assign pop_data = mem_r[rd_ptr_r[ADDR_WIDTH-1:0]];

    // Storage and pointer update; flush only rewinds the pointers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (wr_en_s) begin
                mem_r[wr_ptr_r[ADDR_WIDTH-1:0]] <= push_data;
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (rd_en_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
        end
    end

endmodule

// File: rtl/np_matrix_mult_accum.sv
// ----------------------------------------------------------------------------
// np_matrix_mult_accum
// Accumulates one signed dot-product per kernel from the product stream,
// saturates each finished sum to OUT_WIDTH and queues it (with its kernel
// index) in an output FIFO drained over a valid/ready handshake.
// Ports:
//   clock, reset (async active-low)
//   start    : begin a pass; aborts and restarts a pass already running
//   bus      : slave side of np_matrix_mult_accum_if
//              (prod_valid/prod_data/prod_last in, sum_* out, sum_ready in)
//   busy     : pass in progress (ACCUM or DRAIN)
//   done     : one-cycle pulse the cycle after the pass's final pop
//   overflow : sticky; a finished sum was dropped on a full FIFO
// ACC_WIDTH must be below 64 and at least OUT_WIDTH and PROD_WIDTH.
// ----------------------------------------------------------------------------
module np_matrix_mult_accum #(
    parameter int NUM_KERNELS = 8,
    parameter int PROD_WIDTH  = ffn_pkg::PROD_WIDTH,
    parameter int ACC_WIDTH   = ffn_pkg::ACC_WIDTH,
    parameter int OUT_WIDTH   = ffn_pkg::OUT_WIDTH,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     start,
    np_matrix_mult_accum_if.slave    bus,
    output logic                     busy,
    output logic                     done,
    output logic                     overflow
);

    import ffn_pkg::*;

    localparam int IDX_WIDTH  = $clog2(NUM_KERNELS);
    localparam int CNT_WIDTH  = $clog2(NUM_KERNELS + 1);
    localparam int FIFO_WIDTH = IDX_WIDTH + OUT_WIDTH;
    localparam logic [IDX_WIDTH-1:0] KCNT_LAST = IDX_WIDTH'(NUM_KERNELS - 1);
    localparam logic [IDX_WIDTH-1:0] KCNT_STEP = IDX_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] EMIT_ALL  = CNT_WIDTH'(NUM_KERNELS);

    accum_state_t                  state_r;
    accum_state_t                  state_next;
    logic signed [ACC_WIDTH-1:0]   acc_r;
    logic signed [ACC_WIDTH-1:0]   acc_next;
    logic signed [ACC_WIDTH-1:0]   prod_ext_s;
    logic signed [ACC_WIDTH-1:0]   acc_sum_s;
    logic [IDX_WIDTH-1:0]          kcnt_r;
    logic [IDX_WIDTH-1:0]          kcnt_next;
    logic [CNT_WIDTH-1:0]          emitted_r;
    logic [CNT_WIDTH-1:0]          emitted_next;
    logic                          busy_r;
    logic                          done_r;
    logic                          done_next;
    logic                          overflow_r;
    logic                          overflow_next;
    logic                          push_s;
    logic                          pop_s;
    logic                          flush_s;
    logic                          fifo_full_s;
    logic                          fifo_empty_s;
    logic [OUT_WIDTH-1:0]          sat_s;
    logic [FIFO_WIDTH-1:0]         push_entry_s;
    logic [FIFO_WIDTH-1:0]         head_entry_s;

    assign prod_ext_s = {{(ACC_WIDTH-PROD_WIDTH){bus.prod_data[PROD_WIDTH-1]}}, bus.prod_data};
    // Accumulator wraps at ACC_WIDTH; only the emitted value is clamped.
    assign acc_sum_s  = acc_r + prod_ext_s;
    assign sat_s      = OUT_WIDTH'(sat_to_out({{(64-ACC_WIDTH){acc_sum_s[ACC_WIDTH-1]}}, acc_sum_s},
                                              OUT_WIDTH));

    assign push_entry_s  = {kcnt_r, sat_s};
    assign pop_s         = !fifo_empty_s && bus.sum_ready;
    assign bus.sum_valid = !fifo_empty_s;
    assign bus.sum_index = head_entry_s[FIFO_WIDTH-1 -: IDX_WIDTH];
    assign bus.sum_data  = head_entry_s[OUT_WIDTH-1:0];

    assign busy     = busy_r;
    assign done     = done_r;
    assign overflow = overflow_r;

    np_sum_fifo #(
        .WIDTH (FIFO_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_sum_fifo (
        .clock     (clock),
        .reset     (reset),
        .flush     (flush_s),
        .push      (push_s),
        .push_data (push_entry_s),
        .pop       (pop_s),
        .pop_data  (head_entry_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s)
    );

    // Next-state, accumulator and counter logic; start overrides every state.
    always_comb begin
        state_next   = state_r;
        acc_next     = acc_r;
        kcnt_next    = kcnt_r;
        emitted_next = emitted_r + {{(CNT_WIDTH-1){1'b0}}, pop_s};
        push_s       = 1'b0;
        flush_s      = 1'b0;
        done_next    = 1'b0;
        if (start) begin
            flush_s      = 1'b1;
            acc_next     = '0;
            kcnt_next    = '0;
            emitted_next = '0;
            state_next   = ACCUM;
        end else begin
            case (state_r)
                IDLE: begin
                    state_next = IDLE;
                end
                ACCUM: begin
                    if (bus.prod_valid) begin
                        if (bus.prod_last) begin
                            push_s    = 1'b1;
                            acc_next  = '0;
                            kcnt_next = kcnt_r + KCNT_STEP;
                            if (kcnt_r == KCNT_LAST) begin
                                state_next = DRAIN;
                            end else begin
                                state_next = ACCUM;
                            end
                        end else begin
                            acc_next = acc_sum_s;
                        end
                    end else begin
                        acc_next = acc_r;
                    end
                end
                DRAIN: begin
                    // A dropped entry means this never completes; only start leaves.
                    if (emitted_next == EMIT_ALL) begin
                        state_next = IDLE;
                        done_next  = 1'b1;
                    end else begin
                        state_next = DRAIN;
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // Sticky overflow: set when a push meets a full FIFO with no pop to free a slot.
    always_comb begin
        overflow_next = overflow_r;
        if (flush_s) begin
            overflow_next = 1'b0;
        end else if (push_s && fifo_full_s && !pop_s) begin
            overflow_next = 1'b1;
        end else begin
            overflow_next = overflow_r;
        end
    end

    // State, datapath and registered status outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r    <= IDLE;
            acc_r      <= '0;
            kcnt_r     <= '0;
            emitted_r  <= '0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            overflow_r <= 1'b0;
        end else begin
            state_r    <= state_next;
            acc_r      <= acc_next;
            kcnt_r     <= kcnt_next;
            emitted_r  <= emitted_next;
            busy_r     <= (state_next != IDLE);
            done_r     <= done_next;
            overflow_r <= overflow_next;
        end
    end

endmodule

// File: tb/tb_np_matrix_mult_accum.sv
module tb_np_matrix_mult_accum;

    localparam int NK    = 8;
    localparam int DEPTH = 4;

    logic clock;
    logic reset;
    logic start;
    logic busy;
    logic done;
    logic overflow;

    np_matrix_mult_accum_if #(.PROD_WIDTH(32), .OUT_WIDTH(32), .IDX_WIDTH(3)) bus_if ();

    np_matrix_mult_accum #(
        .NUM_KERNELS (NK),
        .PROD_WIDTH  (32),
        .ACC_WIDTH   (48),
        .OUT_WIDTH   (32),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .bus      (bus_if),
        .busy     (busy),
        .done     (done),
        .overflow (overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          done_cnt = 0;
    int          done_cyc = -1;
    int          last_pop_edge = -2;
    bit          busy_at_done;
    int          obs_idx[$];
    logic [31:0] obs_data[$];
    logic [31:0] exp_data[$];
    longint      m_acc;

    // Reference arithmetic: 48-bit wrapping accumulator, 32-bit saturation.
    function automatic longint wrap48(input longint v);
        longint r;
        r = v & 64'sh0000_FFFF_FFFF_FFFF;
        if (r[47]) r = r - 64'sh0001_0000_0000_0000;
        return r;
    endfunction

    function automatic logic [31:0] sat32(input longint v);
        if (v > 64'sd2147483647) return 32'h7FFF_FFFF;
        else if (v < -64'sd2147483648) return 32'h8000_0000;
        else return v[31:0];
    endfunction

    function automatic logic [31:0] small_rand();
        int v;
        v = int'($urandom_range(0, 2000)) - 1000;
        return v;
    endfunction

    task automatic tick();
        if (bus_if.sum_valid && bus_if.sum_ready) begin
            obs_idx.push_back(int'(bus_if.sum_index));
            obs_data.push_back(bus_if.sum_data);
            last_pop_edge = cyc + 1;
        end
        @(posedge clock);
        #1;
        cyc++;
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
            busy_at_done = busy;
        end
    endtask

    task automatic idle(input int n);
        bus_if.prod_valid = 1'b0;
        bus_if.prod_last  = 1'b0;
        for (int i = 0; i < n; i++) begin
            bus_if.prod_data = $urandom;
            tick();
        end
    endtask

    task automatic send_prod(input logic [31:0] p, input bit last);
        bus_if.prod_valid = 1'b1;
        bus_if.prod_data  = p;
        bus_if.prod_last  = last;
        m_acc = wrap48(m_acc + longint'($signed(p)));
        if (last) begin
            exp_data.push_back(sat32(m_acc));
            m_acc = 0;
        end
        tick();
        bus_if.prod_valid = 1'b0;
        bus_if.prod_last  = 1'b0;
        bus_if.prod_data  = $urandom;
    endtask

    task automatic clear_model();
        m_acc = 0;
        exp_data.delete();
        obs_idx.delete();
        obs_data.delete();
        done_cnt = 0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        clear_model();
    endtask

    task automatic send_random_kernel(input int max_len, input int max_gap);
        int len;
        len = int'($urandom_range(1, max_len));
        for (int j = 0; j < len; j++) begin
            idle(int'($urandom_range(0, max_gap)));
            send_prod(small_rand(), j == len - 1);
        end
    endtask

    task automatic wait_done(input int limit, output bit ok);
        int n;
        int base;
        n = 0;
        base = done_cnt;
        while (done_cnt == base && n < limit) begin
            tick();
            n++;
        end
        ok = (done_cnt != base);
    endtask

    task automatic test_reset();
        checks++; if (bus_if.sum_valid !== 1'b0) begin errors++; $display("FAIL reset_sum_valid: got %b expected 0", bus_if.sum_valid); end
        checks++; if (bus_if.sum_data !== 32'd0) begin errors++; $display("FAIL reset_sum_data: got %h expected 0", bus_if.sum_data); end
        checks++; if (bus_if.sum_index !== 3'd0) begin errors++; $display("FAIL reset_sum_index: got %0d expected 0", bus_if.sum_index); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
    endtask

    task automatic test_basic();
        bit ok;
        bus_if.sum_ready = 1'b1;
        // products while idle must not create entries
        bus_if.prod_valid = 1'b1;
        bus_if.prod_data  = 32'd77;
        bus_if.prod_last  = 1'b1;
        tick();
        tick();
        idle(1);
        checks++; if (bus_if.sum_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL basic_idle_ignore: got valid=%b busy=%b expected 0 0", bus_if.sum_valid, busy); end
        pulse_start();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b expected 1", busy); end
        send_prod(32'd1, 1'b0);
        send_prod(32'd2, 1'b0);
        send_prod(32'd3, 1'b1);
        send_prod(-32'sd5, 1'b0);
        idle(1);
        send_prod(32'd4, 1'b0);
        send_prod(32'd0, 1'b1);
        for (int k = 2; k < NK; k++) send_random_kernel(4, 2);
        wait_done(40, ok);
        checks++; if (!ok) begin errors++; $display("FAIL basic_done_timeout: got no done expected done within 40 cycles"); end
        checks++; if (obs_data.size() != NK) begin errors++; $display("FAIL basic_count: got %0d expected %0d", obs_data.size(), NK); end
        for (int i = 0; i < NK; i++) begin
            checks++;
            if (i >= obs_data.size()) begin errors++; $display("FAIL basic_sum%0d: got nothing expected idx %0d data %h", i, i, exp_data[i]); end
            else if (obs_idx[i] != i || obs_data[i] !== exp_data[i]) begin errors++; $display("FAIL basic_sum%0d: got idx %0d data %h expected idx %0d data %h", i, obs_idx[i], obs_data[i], i, exp_data[i]); end
        end
        if (obs_data.size() >= 2) begin
            checks++; if (obs_data[0] !== 32'd6 || obs_data[1] !== 32'hFFFF_FFFF) begin errors++; $display("FAIL basic_fixed: got %h %h expected 00000006 ffffffff", obs_data[0], obs_data[1]); end
        end
        checks++; if (done_cyc != last_pop_edge) begin errors++; $display("FAIL basic_done_timing: got cycle %0d expected %0d", done_cyc, last_pop_edge); end
        checks++; if (busy_at_done !== 1'b0) begin errors++; $display("FAIL basic_busy_at_done: got %b expected 0", busy_at_done); end
        idle(3);
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL basic_done_count: got %0d expected 1", done_cnt); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL basic_overflow: got %b expected 0", overflow); end
    endtask

    task automatic test_saturation();
        bit ok;
        bus_if.sum_ready = 1'b1;
        pulse_start();
        send_prod(32'h7FFF_FFFF, 1'b0); send_prod(32'h7FFF_FFFF, 1'b1);
        send_prod(32'h8000_0000, 1'b0); send_prod(32'h8000_0000, 1'b1);
        send_prod(32'h7FFF_FFFF, 1'b0); send_prod(32'h7FFF_FFFF, 1'b0);
        send_prod(32'h8000_0000, 1'b0); send_prod(32'h8000_0000, 1'b1);
        send_prod(32'h8000_0000, 1'b1);
        send_prod(32'h7FFF_FFFF, 1'b0); send_prod(32'h0000_0001, 1'b1);
        send_prod(32'h8000_0000, 1'b0); send_prod(32'hFFFF_FFFF, 1'b1);
        for (int k = 6; k < NK; k++) begin
            for (int j = 0; j < 3; j++) send_prod($urandom, j == 2);
        end
        wait_done(40, ok);
        checks++; if (!ok) begin errors++; $display("FAIL sat_done_timeout: got no done expected done within 40 cycles"); end
        for (int i = 0; i < NK; i++) begin
            checks++;
            if (i >= obs_data.size()) begin errors++; $display("FAIL sat_sum%0d: got nothing expected %h", i, exp_data[i]); end
            else if (obs_idx[i] != i || obs_data[i] !== exp_data[i]) begin errors++; $display("FAIL sat_sum%0d: got idx %0d data %h expected idx %0d data %h", i, obs_idx[i], obs_data[i], i, exp_data[i]); end
        end
        if (obs_data.size() >= 3) begin
            checks++; if (obs_data[0] !== 32'h7FFF_FFFF || obs_data[1] !== 32'h8000_0000 || obs_data[2] !== 32'hFFFF_FFFE) begin errors++; $display("FAIL sat_fixed: got %h %h %h expected 7fffffff 80000000 fffffffe", obs_data[0], obs_data[1], obs_data[2]); end
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        logic [31:0] p0;
        bus_if.sum_ready = 1'b1;
        pulse_start();
        p0 = $urandom;
        send_prod(p0, 1'b1);
        checks++; if (bus_if.sum_valid !== 1'b1 || bus_if.sum_index !== 3'd0 || bus_if.sum_data !== p0) begin errors++; $display("FAIL b2b_latency: got valid=%b idx=%0d data=%h expected 1 0 %h", bus_if.sum_valid, bus_if.sum_index, bus_if.sum_data, p0); end
        for (int k = 1; k < NK; k++) send_prod($urandom, 1'b1);
        wait_done(20, ok);
        checks++; if (!ok) begin errors++; $display("FAIL b2b_done_timeout: got no done expected done within 20 cycles"); end
        for (int i = 0; i < NK; i++) begin
            checks++;
            if (i >= obs_data.size()) begin errors++; $display("FAIL b2b_sum%0d: got nothing expected %h", i, exp_data[i]); end
            else if (obs_idx[i] != i || obs_data[i] !== exp_data[i]) begin errors++; $display("FAIL b2b_sum%0d: got idx %0d data %h expected idx %0d data %h", i, obs_idx[i], obs_data[i], i, exp_data[i]); end
        end
        checks++; if (done_cyc != last_pop_edge) begin errors++; $display("FAIL b2b_done_timing: got cycle %0d expected %0d", done_cyc, last_pop_edge); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL b2b_overflow: got %b expected 0", overflow); end
    endtask

    task automatic test_backpressure();
        int n;
        bus_if.sum_ready = 1'b0;
        pulse_start();
        for (int k = 0; k < 4; k++) send_random_kernel(3, 1);
        checks++; if (overflow !== 1'b0 || bus_if.sum_valid !== 1'b1) begin errors++; $display("FAIL bp_before_fifth: got ovf=%b valid=%b expected 0 1", overflow, bus_if.sum_valid); end
        send_random_kernel(3, 1);
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL bp_overflow: got %b expected 1", overflow); end
        idle(3);
        checks++; if (bus_if.sum_index !== 3'd0 || bus_if.sum_data !== exp_data[0]) begin errors++; $display("FAIL bp_head_stable: got idx %0d data %h expected 0 %h", bus_if.sum_index, bus_if.sum_data, exp_data[0]); end
        bus_if.sum_ready = 1'b1;
        n = 0;
        while (obs_data.size() < 4 && n < 20) begin idle(1); n++; end
        idle(1);
        checks++; if (obs_data.size() != 4 || bus_if.sum_valid !== 1'b0) begin errors++; $display("FAIL bp_retained: got %0d entries valid=%b expected 4 entries valid=0", obs_data.size(), bus_if.sum_valid); end
        for (int i = 0; i < 4 && i < obs_data.size(); i++) begin
            checks++; if (obs_idx[i] != i || obs_data[i] !== exp_data[i]) begin errors++; $display("FAIL bp_pop%0d: got idx %0d data %h expected idx %0d data %h", i, obs_idx[i], obs_data[i], i, exp_data[i]); end
        end
        for (int k = 5; k < NK; k++) send_prod(small_rand(), 1'b1);
        idle(4);
        for (int j = 0; j < 3; j++) begin
            checks++;
            if (4 + j >= obs_data.size()) begin errors++; $display("FAIL bp_late%0d: got nothing expected idx %0d", j, 5 + j); end
            else if (obs_idx[4+j] != 5 + j || obs_data[4+j] !== exp_data[5+j]) begin errors++; $display("FAIL bp_late%0d: got idx %0d data %h expected idx %0d data %h", j, obs_idx[4+j], obs_data[4+j], 5 + j, exp_data[5+j]); end
        end
        checks++; if (done_cnt != 0 || busy !== 1'b1 || overflow !== 1'b1) begin errors++; $display("FAIL bp_stuck_drain: got done_cnt=%0d busy=%b ovf=%b expected 0 1 1", done_cnt, busy, overflow); end
    endtask

    task automatic test_abort();
        bit ok;
        bus_if.sum_ready = 1'b0;
        pulse_start();
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL abort_start_clears: got %b expected 0", overflow); end
        for (int k = 0; k < 5; k++) send_prod(small_rand(), 1'b1);
        send_prod(32'h0012_3456, 1'b0);
        checks++; if (overflow !== 1'b1 || bus_if.sum_valid !== 1'b1) begin errors++; $display("FAIL abort_setup: got ovf=%b valid=%b expected 1 1", overflow, bus_if.sum_valid); end
        start = 1'b1;
        bus_if.prod_valid = 1'b1;
        bus_if.prod_data  = 32'h0BAD_0BAD;
        bus_if.prod_last  = 1'b1;
        tick();
        start = 1'b0;
        bus_if.prod_valid = 1'b0;
        bus_if.prod_last  = 1'b0;
        clear_model();
        checks++; if (bus_if.sum_valid !== 1'b0 || overflow !== 1'b0 || busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL abort_flush: got valid=%b ovf=%b busy=%b done=%b expected 0 0 1 0", bus_if.sum_valid, overflow, busy, done); end
        bus_if.sum_ready = 1'b1;
        for (int k = 0; k < NK; k++) send_random_kernel(3, 1);
        wait_done(40, ok);
        checks++; if (!ok || done_cnt != 1) begin errors++; $display("FAIL abort_done: got done_cnt=%0d expected 1", done_cnt); end
        for (int i = 0; i < NK; i++) begin
            checks++;
            if (i >= obs_data.size()) begin errors++; $display("FAIL abort_sum%0d: got nothing expected %h", i, exp_data[i]); end
            else if (obs_idx[i] != i || obs_data[i] !== exp_data[i]) begin errors++; $display("FAIL abort_sum%0d: got idx %0d data %h expected idx %0d data %h", i, obs_idx[i], obs_data[i], i, exp_data[i]); end
        end
    endtask

    task automatic test_reset_drain();
        bit ok;
        bus_if.sum_ready = 1'b0;
        pulse_start();
        for (int k = 0; k < NK; k++) send_prod(small_rand(), 1'b1);
        idle(1);
        checks++; if (busy !== 1'b1 || bus_if.sum_valid !== 1'b1) begin errors++; $display("FAIL rd_setup: got busy=%b valid=%b expected 1 1", busy, bus_if.sum_valid); end
        reset = 1'b0;
        #1;
        checks++; if (bus_if.sum_valid !== 1'b0 || bus_if.sum_data !== 32'd0 || bus_if.sum_index !== 3'd0) begin errors++; $display("FAIL rd_sum_reset: got valid=%b data=%h idx=%0d expected 0 0 0", bus_if.sum_valid, bus_if.sum_data, bus_if.sum_index); end
        checks++; if (busy !== 1'b0 || done !== 1'b0 || overflow !== 1'b0) begin errors++; $display("FAIL rd_status_reset: got busy=%b done=%b ovf=%b expected 0 0 0", busy, done, overflow); end
        tick();
        reset = 1'b1;
        bus_if.sum_ready = 1'b1;
        pulse_start();
        for (int k = 0; k < NK; k++) send_random_kernel(2, 1);
        wait_done(40, ok);
        checks++; if (!ok || done_cnt != 1) begin errors++; $display("FAIL rd_done: got done_cnt=%0d expected 1", done_cnt); end
        for (int i = 0; i < NK; i++) begin
            checks++;
            if (i >= obs_data.size()) begin errors++; $display("FAIL rd_sum%0d: got nothing expected %h", i, exp_data[i]); end
            else if (obs_idx[i] != i || obs_data[i] !== exp_data[i]) begin errors++; $display("FAIL rd_sum%0d: got idx %0d data %h expected idx %0d data %h", i, obs_idx[i], obs_data[i], i, exp_data[i]); end
        end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rd_overflow: got %b expected 0", overflow); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b0;
        start = 1'b0;
        bus_if.prod_valid = 1'b0;
        bus_if.prod_data  = 32'd0;
        bus_if.prod_last  = 1'b0;
        bus_if.sum_ready  = 1'b0;
        m_acc = 0;
        #3;
        test_reset();
        @(posedge clock);
        #1;
        reset = 1'b1;
        test_basic();
        test_saturation();
        test_back_to_back();
        test_backpressure();
        test_abort();
        test_reset_drain();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
